// File: rtl/reg_bank.sv
// reg_bank: 32-entry register file with write-through bypass and a ready/valid debug dump stream.
module reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic                  DumpStart,
    input  logic                  DumpReady,
    output logic                  DumpValid,
    output logic [ADDR_WIDTH-1:0] DumpIndex,
    output logic [DATA_WIDTH-1:0] DumpData,
    output logic                  DumpBusy,
    output logic                  DumpDone
);
    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NREG - 1);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [ADDR_WIDTH-1:0] idx, idx_n;
    logic [DATA_WIDTH-1:0] data, data_n;
    logic we;
    assign we = RegWrite && !Reset && WriteRegister != '0;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[WriteRegister] <= WriteData;
        end
    end
    assign ReadData1 = (ReadRegister1 == '0) ? '0 :
                       (we && WriteRegister == ReadRegister1) ? WriteData : regs[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == '0) ? '0 :
                       (we && WriteRegister == ReadRegister2) ? WriteData : regs[ReadRegister2];
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            idx   <= '0;
            data  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            data  <= data_n;
        end
    end
    // Displayed word only reloads on a transfer, so stalls hold it even if the register changes.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        data_n  = data;
        if (state == IDLE && DumpStart) begin
            state_n = SEND;
            idx_n   = '0;
            data_n  = '0;
        end else if (state == SEND && DumpReady) begin
            if (idx == LAST) begin
                state_n = DONE;
            end else begin
                idx_n  = idx + 1'b1;
                data_n = (we && WriteRegister == idx_n) ? WriteData : regs[idx_n];
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    assign DumpValid = state == SEND;
    assign DumpBusy  = state != IDLE;
    assign DumpDone  = state == DONE;
    assign DumpIndex = idx;
    assign DumpData  = data;
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: randomized self-checking bench for reg_bank against an array model of the register file.
module tb_reg_bank;
    logic        Clk = 0;
    logic        Reset = 1;
    logic        RegWrite = 0;
    logic [4:0]  WriteRegister = 0;
    logic [31:0] WriteData = 0;
    logic [4:0]  ReadRegister1 = 0;
    logic [4:0]  ReadRegister2 = 0;
    logic [31:0] ReadData1, ReadData2;
    logic        DumpStart = 0;
    logic        DumpReady = 0;
    logic        DumpValid;
    logic [4:0]  DumpIndex;
    logic [31:0] DumpData;
    logic        DumpBusy, DumpDone;
    int errors = 0;
    int checks = 0;
    logic [31:0] model [32];

    reg_bank dut (
        .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .DumpStart(DumpStart),
        .DumpReady(DumpReady), .DumpValid(DumpValid), .DumpIndex(DumpIndex),
        .DumpData(DumpData), .DumpBusy(DumpBusy), .DumpDone(DumpDone)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] expect_read(input logic [4:0] ra);
        if (ra == 0) return 32'h0;
        if (RegWrite && WriteRegister == ra) return WriteData;
        return model[ra];
    endfunction

    task automatic tick();
        @(posedge Clk);
        if (RegWrite && WriteRegister != 0) model[WriteRegister] = WriteData;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1;
        RegWrite = 1; WriteRegister = 9; WriteData = 32'hCAFEF00D;
        @(posedge Clk); #1;
        RegWrite = 0;
        checks++;
        if ({DumpValid, DumpBusy, DumpDone} !== 3'b000 || DumpIndex !== 5'd0 || DumpData !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid/busy/done=%b%b%b idx=%0d data=%h, want 000 0 0",
                     DumpValid, DumpBusy, DumpDone, DumpIndex, DumpData);
        end
        Reset = 0;
        for (int i = 0; i < 32; i++) model[i] = 0;
        for (int i = 0; i < 32; i += 3) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i); #1;
            checks++;
            if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_regs: r%0d=%h r%0d=%h, want 0", i, ReadData1, 31 - i, ReadData2);
            end
        end
        ReadRegister1 = 9; #1;
        checks++;
        if (ReadData1 !== 32'h0) begin
            errors++;
            $display("FAIL write_during_reset: r9=%h, want 0", ReadData1);
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1; WriteRegister = 5; WriteData = 32'hDEADBEEF;
        tick();
        RegWrite = 0; ReadRegister1 = 5; #1;
        checks++;
        if (ReadData1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r5: got %h, want deadbeef", ReadData1);
        end
        RegWrite = 1; WriteRegister = 0; WriteData = 32'h12345678;
        tick();
        RegWrite = 0; ReadRegister2 = 0; #1;
        checks++;
        if (ReadData2 !== 32'h0) begin
            errors++;
            $display("FAIL write_r0: got %h, want 0", ReadData2);
        end
        for (int n = 0; n < 60; n++) begin
            RegWrite = 1'($urandom_range(0, 1));
            WriteRegister = 5'($urandom_range(0, 31));
            WriteData = $urandom;
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (ReadData1 !== expect_read(ReadRegister1) || ReadData2 !== expect_read(ReadRegister2)) begin
                errors++;
                $display("FAIL rand_read: r%0d=%h r%0d=%h, want %h %h", ReadRegister1, ReadData1,
                         ReadRegister2, ReadData2, expect_read(ReadRegister1), expect_read(ReadRegister2));
            end
            tick();
        end
        RegWrite = 0;
    endtask

    task automatic test_bypass();
        RegWrite = 1; WriteRegister = 7; WriteData = 32'hA5A5A5A5;
        ReadRegister1 = 7; ReadRegister2 = 7; #1;
        checks++;
        if (ReadData1 !== 32'hA5A5A5A5 || ReadData2 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_r7: got %h %h, want a5a5a5a5", ReadData1, ReadData2);
        end
        tick();
        RegWrite = 0;
    endtask

    task automatic preload_scaled();
        for (int n = 1; n < 32; n++) begin
            RegWrite = 1; WriteRegister = 5'(n); WriteData = 32'(n * 32'h10);
            tick();
        end
        RegWrite = 0;
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random; r3_stall writes R3 while index 3 is stalled.
    task automatic run_dump(input int ready_mode, input bit rnd_writes, input bit r3_stall);
        int exp_idx = 0;
        logic [31:0] exp_data = 0;
        int transfers = 0;
        int cyc = 0;
        bit done = 0;
        bit xfer;
        RegWrite = 0; DumpReady = 0; DumpStart = 1;
        tick();
        DumpStart = 0;
        while (!done && cyc < 400) begin
            cyc++;
            checks++;
            if (DumpValid !== 1 || DumpBusy !== 1 || DumpDone !== 0 ||
                DumpIndex !== 5'(exp_idx) || DumpData !== exp_data) begin
                errors++;
                $display("FAIL dump_word: v/b/d=%b%b%b idx=%0d data=%h, want 110 idx=%0d data=%h",
                         DumpValid, DumpBusy, DumpDone, DumpIndex, DumpData, exp_idx, exp_data);
            end
            DumpReady = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            DumpStart = 1'($urandom_range(0, 1));
            RegWrite = 0;
            if (r3_stall && exp_idx == 3 && !DumpReady) begin
                RegWrite = 1; WriteRegister = 3; WriteData = 32'h55;
            end else if (rnd_writes && $urandom_range(0, 1) == 1) begin
                RegWrite = 1; WriteRegister = 5'($urandom_range(0, 31)); WriteData = $urandom;
                if ($urandom_range(0, 2) == 0) WriteRegister = 5'((exp_idx + 1) % 32);
            end
            ReadRegister1 = 5'($urandom_range(0, 31)); #1;
            checks++;
            if (ReadData1 !== expect_read(ReadRegister1)) begin
                errors++;
                $display("FAIL read_during_dump: r%0d=%h, want %h", ReadRegister1, ReadData1,
                         expect_read(ReadRegister1));
            end
            xfer = DumpReady;
            tick();
            if (xfer) begin
                transfers++;
                if (exp_idx == 31) done = 1;
                else begin
                    exp_idx++;
                    exp_data = model[exp_idx];
                end
            end
        end
        RegWrite = 0; DumpStart = 0; DumpReady = 0;
        checks++;
        if (!done || transfers != 32) begin
            errors++;
            $display("FAIL dump_count: transfers=%0d finished=%0d, want 32 1", transfers, done);
        end
        checks++;
        if (DumpDone !== 1 || DumpValid !== 0 || DumpBusy !== 1) begin
            errors++;
            $display("FAIL dump_done: done/valid/busy=%b%b%b, want 101", DumpDone, DumpValid, DumpBusy);
        end
        tick();
        checks++;
        if (DumpDone !== 0 || DumpValid !== 0 || DumpBusy !== 0) begin
            errors++;
            $display("FAIL dump_idle: done/valid/busy=%b%b%b, want 000", DumpDone, DumpValid, DumpBusy);
        end
    endtask

    task automatic test_dump_full();
        preload_scaled();
        run_dump(0, 0, 0);
    endtask

    task automatic test_dump_stall();
        preload_scaled();
        run_dump(1, 0, 1);
        ReadRegister2 = 3; #1;
        checks++;
        if (ReadData2 !== 32'h55) begin
            errors++;
            $display("FAIL stall_write_r3: got %h, want 00000055", ReadData2);
        end
    endtask

    task automatic test_back_to_back();
        run_dump(2, 1, 0);
        run_dump(2, 1, 0);
    endtask

    task automatic test_reset_mid_dump();
        int cyc = 0;
        preload_scaled();
        DumpReady = 1; DumpStart = 1;
        tick();
        while (DumpIndex != 5'd10 && cyc < 100) begin
            cyc++;
            DumpStart = (DumpIndex == 5'd5);
            tick();
        end
        DumpStart = 0;
        checks++;
        if (cyc != 10) begin
            errors++;
            $display("FAIL reach_idx10: cycles=%0d, want 10", cyc);
        end
        Reset = 1; #1;
        for (int i = 0; i < 32; i++) model[i] = 0;
        checks++;
        if ({DumpValid, DumpBusy, DumpDone} !== 3'b000 || DumpIndex !== 5'd0 || DumpData !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: v/b/d=%b%b%b idx=%0d data=%h, want 000 0 0",
                     DumpValid, DumpBusy, DumpDone, DumpIndex, DumpData);
        end
        for (int i = 1; i < 32; i += 5) begin
            ReadRegister1 = 5'(i); #1;
            checks++;
            if (ReadData1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_clears_r%0d: got %h, want 0", i, ReadData1);
            end
        end
        @(posedge Clk); #1;
        Reset = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (DumpDone !== 0 || DumpBusy !== 0 || DumpValid !== 0) begin
                errors++;
                $display("FAIL after_abort: done/busy/valid=%b%b%b, want 000", DumpDone, DumpBusy, DumpValid);
            end
        end
        DumpReady = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_dump_full();
        test_dump_stall();
        test_back_to_back();
        test_reset_mid_dump();
        test_write_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_WIDTH, 32, register and data width in bits.
REQ-002 Parameter ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH (32).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 RegWrite  input  1  write-back enable from the WB stage.
REQ-006 WriteRegister  input  ADDR_WIDTH  write-back destination index.
REQ-007 WriteData  input  DATA_WIDTH  write-back data (WB stage MemToReg_Out).
REQ-008 ReadRegister1 / ReadRegister2  input  ADDR_WIDTH each  decode-stage source indices.
REQ-009 ReadData1 / ReadData2  output  DATA_WIDTH each  decode-stage operand data.
REQ-010 DumpStart  input  1  one-cycle request to stream the full register bank to the debug unit.
REQ-011 DumpReady  input  1  debug consumer ready to accept a word.
REQ-012 DumpValid  output  1  DumpIndex/DumpData hold a valid word.
REQ-013 DumpIndex  output  ADDR_WIDTH  index of the word on DumpData.
REQ-014 DumpData  output  DATA_WIDTH  register contents being streamed.
REQ-015 DumpBusy  output  1  high while the dump FSM is not IDLE.
REQ-016 DumpDone  output  1  one-cycle pulse after the last word transfers.

Function
REQ-017 Write: rising edge with RegWrite=1 and WriteRegister!=0 SHALL store WriteData; writes to index 0 SHALL be discarded.
REQ-018 Read ports SHALL be combinational, zero-cycle latency; index 0 SHALL always read 0.
REQ-019 Bypass: when RegWrite=1, WriteRegister!=0 and WriteRegister equals a ReadRegister, that port SHALL return WriteData in the same cycle.
REQ-020 Both read ports SHALL be independent; identical indices SHALL return identical data.
REQ-021 Dump FSM states: IDLE, SEND, DONE.
REQ-022 IDLE: DumpStart=1 -> SEND next cycle with DumpIndex=0 and DumpData loaded with bypassed value of register 0.
REQ-023 SEND: DumpValid=1; transfer occurs on a rising edge with DumpValid=1 and DumpReady=1.
REQ-024 SEND: DumpIndex/DumpData SHALL remain stable while DumpReady=0, even if the displayed register is written meanwhile.
REQ-025 SEND transfer with DumpIndex<31: DumpIndex increments by 1 and DumpData reloads with the bypassed value of the new index (a same-edge write to that index SHALL be captured).
REQ-026 SEND transfer with DumpIndex=31 -> DONE; DumpIndex SHALL not wrap to 0 while Valid.
REQ-027 DONE: DumpDone=1, DumpValid=0 for exactly one cycle, then IDLE.
REQ-028 DumpStart SHALL be ignored in SEND and DONE; DumpBusy=1 in SEND and DONE, 0 in IDLE.
REQ-029 Write-back and decode reads SHALL operate unchanged during a dump; the dump SHALL never stall the pipeline.

Reset
REQ-030 Reset=1 SHALL immediately clear all registers to 0, force FSM to IDLE, and drive DumpValid, DumpBusy, DumpDone, DumpIndex, DumpData to 0.
REQ-031 Reset asserted mid-dump SHALL abort it without DumpDone; a new dump requires a fresh DumpStart after Reset deasserts.
REQ-032 Writes SHALL be suppressed while Reset=1.

Verification
REQ-033 Write R5=0xDEADBEEF, next cycle ReadRegister1=5 -> ReadData1=0xDEADBEEF; write R0=0x12345678 -> ReadRegister2=0 returns 0.
REQ-034 Same cycle RegWrite=1, WriteRegister=7, WriteData=0xA5A5A5A5, ReadRegister1=ReadRegister2=7 -> both read 0xA5A5A5A5 before the edge.
REQ-035 Preload Rn=n*0x10 (n=1..31), pulse DumpStart, DumpReady=1 -> 32 consecutive transfers index 0..31 data 0,0x10..0x1F0, then DumpDone pulse one cycle, DumpBusy low after.
REQ-036 Dump with DumpReady toggling 1/0 every cycle while writing R3=0x55 during index-3 stall -> index 3 data held stable until accepted; total 32 transfers in order, no duplicates or skips.
REQ-037 Assert Reset at DumpIndex=10 -> outputs 0 immediately, no DumpDone, all registers read 0; DumpStart during SEND ignored (no restart).
